ws2812_frame_scheduler: RTL and testbench

Sequences one shared WS2812 pixel serializer across 16 LED strip channels. SPI-side logic marks channels dirty; this block picks dirty channels round-robin, streams the channel's pixels from the shared pixel buffer into the serializer, then holds the strip latch gap before serving the next channel. It sits between the SPI pixel buffer (synchronous RAM), the WS2812 bit serializer and the output channel mux.

---
 rtl/ws2812_frame_scheduler.sv | 141 ++++++++++++++
 tb/tb_ws2812_frame_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_scheduler.sv
// Round-robin scheduler that shares one WS2812 serializer across NUM_CH strips.
// It grants a dirty channel, streams that channel's pixels from the buffer, then holds the latch gap.
module ws2812_frame_scheduler #(
  parameter int NUM_CH       = 16,
  parameter int NUM_PIX      = 8,
  parameter int LATCH_CYCLES = 6000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 req,
  output logic [NUM_CH-1:0]                 pending,
  output logic                              busy,
  output logic [$clog2(NUM_CH)-1:0]         ch_sel,
  output logic                              rd_en,
  output logic [$clog2(NUM_CH*NUM_PIX)-1:0] rd_addr,
  input  logic [23:0]                       rd_data,
  output logic [23:0]                       px_data,
  output logic                              px_valid,
  input  logic                              px_ready,
  input  logic                              ser_idle,
  output logic                              latch
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PIX_W = $clog2(NUM_PIX);
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DRAIN,
    LATCH
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   last_ch;
  logic [PIX_W-1:0]  pix;
  logic [CNT_W-1:0]  cnt;

  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   idx;
  logic              grant_vld;
  logic [NUM_CH-1:0] grant_mask;

  // Search starts one past the last served channel, so the served channel
  // itself is considered last (i == NUM_CH wraps back to last_ch).
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last_ch + CH_W'(i);
      if (!grant_vld && pending[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  assign grant_mask = (state == IDLE && grant_vld) ? (NUM_CH'(1) << grant_ch) : '0;

  // A req arriving together with the grant of the same channel keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ch_sel   <= '0;
      last_ch  <= CH_W'(NUM_CH - 1);
      pix      <= '0;
      cnt      <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      px_data  <= '0;
      px_valid <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ch_sel  <= grant_ch;
            pix     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= {grant_ch, PIX_W'(0)};
            state   <= READ;
          end
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          px_data  <= rd_data;
          px_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (px_ready) begin
            px_valid <= 1'b0;
            if (pix == PIX_W'(NUM_PIX - 1)) begin
              state <= DRAIN;
            end else begin
              pix     <= pix + 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= {ch_sel, pix + 1'b1};
              state   <= READ;
            end
          end
        end
        DRAIN: begin
          if (ser_idle) begin
            cnt   <= CNT_W'(LATCH_CYCLES - 1);
            state <= LATCH;
          end
        end
        LATCH: begin
          if (cnt == '0) begin
            last_ch <= ch_sel;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign latch = (state == LATCH);

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler: directed and random frames are checked against a round-robin frame model,
// a buffer model and a serializer model.
module tb_ws2812_frame_scheduler;

  localparam int NCH  = 16;
  localparam int NPIX = 4;
  localparam int LAT  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] pending;
  logic        busy;
  logic [3:0]  ch_sel;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [23:0] rd_data = '0;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic        ser_idle;
  logic        latch;

  ws2812_frame_scheduler #(
    .NUM_CH(NCH),
    .NUM_PIX(NPIX),
    .LATCH_CYCLES(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .pending(pending),
    .busy(busy),
    .ch_sel(ch_sel),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .px_data(px_data),
    .px_valid(px_valid),
    .px_ready(px_ready),
    .ser_idle(ser_idle),
    .latch(latch)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [NCH*NPIX];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  logic ready_rand = 1'b0, ready_auto = 1'b1, ready_man_en = 1'b0, ready_man = 1'b1;
  logic idle_rand = 1'b0, idle_auto = 1'b1, idle_man_en = 1'b0, idle_man = 1'b1;
  always @(posedge clk) begin
    #1;
    ready_auto = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    idle_auto  = idle_rand ? ($urandom_range(0, 3) == 0) : 1'b1;
  end
  assign px_ready = ready_man_en ? ready_man : ready_auto;
  assign ser_idle = idle_man_en ? idle_man : idle_auto;

  logic [5:0]  rd_log[$];
  logic [27:0] hs_log[$];
  int          lat_log[$];
  int          lat_run = 0;
  int          prot_err = 0;
  logic        p_rd = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_busy = 1'b0;
  logic [23:0] p_data = '0;
  logic [3:0]  p_ch = '0;

  // Observes read strobes, handshakes, latch pulses and the stability rules.
  always @(negedge clk) begin
    if (rst) begin
      p_rd = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_busy = 1'b0; lat_run = 0;
    end else begin
      if (rd_en) begin
        rd_log.push_back(rd_addr);
        if (p_rd) prot_err++;
      end
      if (px_valid && px_ready) hs_log.push_back({ch_sel, px_data});
      if (p_valid && !p_ready && (!px_valid || px_data != p_data)) prot_err++;
      if (p_busy && busy && ch_sel != p_ch) prot_err++;
      if (latch) lat_run++;
      else if (lat_run != 0) begin
        lat_log.push_back(lat_run);
        lat_run = 0;
      end
      p_rd = rd_en; p_valid = px_valid; p_ready = px_ready; p_data = px_data;
      p_busy = busy; p_ch = ch_sel;
    end
  end

  int passed = 0;
  int total  = 0;
  int exp_ch[$];
  int mlast = NCH - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    hs_log.delete();
    lat_log.delete();
    exp_ch.delete();
  endtask

  task automatic pulse(input logic [15:0] m);
    req = m;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pending"}, 32'(pending), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " ch_sel"}, 32'(ch_sel), 0);
    chk({tag, " rd_en"}, 32'(rd_en), 0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 0);
    chk({tag, " px_data"}, 32'(px_data), 0);
    chk({tag, " px_valid"}, 32'(px_valid), 0);
    chk({tag, " latch"}, 32'(latch), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mlast = NCH - 1;
    clear_logs();
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int t = 0;
    while ((busy || pending != 0) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, " finishes in time"}, 32'(t < budget), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Spec rule: serve set bits in order starting one above the last served channel, wrapping.
  function automatic void plan_rr(input logic [15:0] mask);
    for (int i = 1; i <= NCH; i++) begin
      int c = (mlast + i) % NCH;
      if (mask[c]) exp_ch.push_back(c);
    end
  endfunction

  task automatic check_logs(input string tag);
    int n = exp_ch.size();
    int a;
    logic [3:0] c4;
    chk({tag, " rd count"}, 32'(rd_log.size()), 32'(NPIX * n));
    chk({tag, " hs count"}, 32'(hs_log.size()), 32'(NPIX * n));
    chk({tag, " latch pulses"}, 32'(lat_log.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      c4 = 4'(exp_ch[k]);
      for (int p = 0; p < NPIX; p++) begin
        a = exp_ch[k] * NPIX + p;
        if (NPIX * k + p < rd_log.size()) chk({tag, " rd_addr"}, 32'(rd_log[NPIX*k+p]), 32'(a));
        if (NPIX * k + p < hs_log.size())
          chk({tag, " ch/px_data"}, 32'(hs_log[NPIX*k+p]), 32'({c4, mem[a]}));
      end
      if (k < lat_log.size()) chk({tag, " latch width"}, 32'(lat_log[k]), LAT);
    end
    chk({tag, " protocol"}, 32'(prot_err), 0);
    chk({tag, " pending end"}, 32'(pending), 0);
    chk({tag, " busy end"}, 32'(busy), 0);
    if (n > 0) mlast = exp_ch[n-1];
    clear_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [15:0] m;
    for (int i = 0; i < NCH * NPIX; i++) mem[i] = 24'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Single channel 0 with cycle-exact start-up timing.
    pulse(16'h0001);
    chk("A cyc0 busy", 32'(busy), 0);
    chk("A cyc0 pending", 32'(pending), 1);
    @(posedge clk); #1;
    chk("A cyc1 rd_en", 32'(rd_en), 1);
    chk("A cyc1 rd_addr", 32'(rd_addr), 0);
    chk("A cyc1 busy", 32'(busy), 1);
    chk("A cyc1 pending", 32'(pending), 0);
    @(posedge clk); #1;
    chk("A cyc2 rd_en", 32'(rd_en), 0);
    chk("A cyc2 px_valid", 32'(px_valid), 0);
    @(posedge clk); #1;
    chk("A cyc3 px_valid", 32'(px_valid), 1);
    chk("A cyc3 px_data", 32'(px_data), 32'(mem[0]));
    exp_ch.push_back(0);
    wait_quiet("A", 500);
    check_logs("A");

    // Two channels in one pulse after reset, then 1 before 2 with last_ch=15.
    do_reset();
    pulse(16'h8001);
    exp_ch.push_back(0); exp_ch.push_back(15);
    wait_quiet("B1", 1000);
    check_logs("B1");
    pulse(16'h0006);
    exp_ch.push_back(1); exp_ch.push_back(2);
    wait_quiet("B2", 1000);
    check_logs("B2");

    // Serializer stalls for 5 cycles on pixel 2 of channel 4.
    ready_man_en = 1'b1; ready_man = 1'b1;
    pulse(16'h0010);
    t = 0;
    while (!(px_valid && hs_log.size() == 2) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("C reach pixel 2", 32'(t < 200), 1);
    ready_man = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      chk("C stall px_valid", 32'(px_valid), 1);
      chk("C stall px_data", 32'(px_data), 32'(mem[4*NPIX+2]));
      chk("C stall no handshake", 32'(hs_log.size()), 2);
    end
    ready_man = 1'b1;
    exp_ch.push_back(4);
    wait_quiet("C", 500);
    ready_man_en = 1'b0;
    check_logs("C");

    // Re-request channel 3 while it is being sent.
    pulse(16'h0008);
    t = 0;
    while (!(px_valid && ch_sel == 3) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("D reach SEND", 32'(t < 200), 1);
    pulse(16'h0008);
    chk("D re-set pending", 32'(pending), 32'h0008);
    exp_ch.push_back(3); exp_ch.push_back(3);
    wait_quiet("D", 1000);
    check_logs("D");

    // Serializer busy for 10 cycles after the last handshake of channel 6.
    idle_man_en = 1'b1; idle_man = 1'b0;
    pulse(16'h0040);
    t = 0;
    while (hs_log.size() != NPIX && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("E last handshake", 32'(t < 200), 1);
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      chk("E drain latch", 32'(latch), 0);
      chk("E drain busy", 32'(busy), 1);
    end
    idle_man = 1'b1;
    @(posedge clk); #1;
    chk("E latch rises", 32'(latch), 1);
    exp_ch.push_back(6);
    wait_quiet("E", 500);
    idle_man_en = 1'b0;
    check_logs("E");

    // Random masks with random serializer backpressure and drain time.
    ready_rand = 1'b1; idle_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      m = 16'($urandom_range(1, 16'hFFFF));
      pulse(m);
      plan_rr(m);
      wait_quiet("R", 5000);
      check_logs("R");
    end
    ready_rand = 1'b0; idle_rand = 1'b0;

    // Reset during pixel 1 of channel 5 while channel 7 is pending.
    pulse(16'h0020);
    pulse(16'h0080);
    t = 0;
    while (!(px_valid && hs_log.size() == 1) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("G reach pixel 1", 32'(t < 200), 1);
    chk("G ch_sel", 32'(ch_sel), 5);
    chk("G pending 7", 32'(pending), 32'h0080);
    rst = 1'b1;
    #1;
    chk_reset("G reset");
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("G quiet busy", 32'(busy), 0);
    chk("G quiet pending", 32'(pending), 0);
    chk("G quiet reads", 32'(rd_log.size()), 0);
    chk("G quiet handshakes", 32'(hs_log.size()), 0);
    pulse(16'h0004);
    exp_ch.push_back(2);
    wait_quiet("G", 500);
    check_logs("G");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
